datapath2: RTL and testbench

DATAPATH2 -- requirements
Module: datapath2

---
 rtl/datapath2.sv | 140 ++++++++++++++
 tb/tb_datapath2.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/datapath2.sv
// Single-bus processor datapath: register file, PC/MAR/MDR/IR/Y/Z, ALU,
// branch condition flip-flop, outport and a 512-word RAM with combinational read.
module datapath2 (
   input  logic        clk,
   input  logic        clr,
   input  logic        PCout,
   input  logic        Zlowout,
   input  logic        MDRout,
   input  logic        MBIout,
   input  logic        Cout,
   input  logic        Rout,
   input  logic        BAout,
   input  logic        Gra,
   input  logic        Grb,
   input  logic        Grc,
   input  logic        Rin,
   input  logic        PCin,
   input  logic        MARin,
   input  logic        MDRin,
   input  logic        IRin,
   input  logic        Yin,
   input  logic        Zin,
   input  logic        CONin,
   input  logic        OutportIn,
   input  logic        Read,
   input  logic        Write,
   input  logic [4:0]  OpCode,
   input  logic [31:0] manualBusInput,
   output logic        ConOtp,
   output logic [31:0] OutportOut
);

   logic [31:0] r_pc, r_mar, r_mdr, r_ir, r_y, r_z, r_out;
   logic        r_con;
   logic [31:0] r_rf  [16];
   logic [31:0] r_mem [512];

   logic [15:0] w_sel;
   logic [31:0] w_rdata, w_bus, w_alu, w_mem_rd;
   logic [4:0]  w_sh;
   logic [63:0] w_rot_r, w_rot_l;
   logic        w_cond;
   logic        w_unused;

   always_comb begin
      w_sel = '0;
      if (Gra) w_sel[r_ir[26:23]] = 1'b1;
      if (Grb) w_sel[r_ir[22:19]] = 1'b1;
      if (Grc) w_sel[r_ir[18:15]] = 1'b1;
   end

   // BAout reads R0 as zero so it can serve as a base-address source
   always_comb begin
      w_rdata = '0;
      for (int unsigned i = 0; i < 16; i++)
         if (w_sel[i] && (Rout || (BAout && i != 0)))
            w_rdata = w_rdata | r_rf[i];
   end

   always_comb begin
      if      (MBIout)        w_bus = manualBusInput;
      else if (PCout)         w_bus = r_pc;
      else if (Zlowout)       w_bus = r_z;
      else if (MDRout)        w_bus = r_mdr;
      else if (Rout || BAout) w_bus = w_rdata;
      else if (Cout)          w_bus = {{13{r_ir[18]}}, r_ir[18:0]};
      else                    w_bus = '0;
   end

   assign w_sh    = w_bus[4:0];
   assign w_rot_r = {r_y, r_y} >> w_sh;
   assign w_rot_l = {r_y, r_y} << w_sh;

   always_comb begin
      case (OpCode)
         5'd0:    w_alu = r_y & w_bus;
         5'd1:    w_alu = r_y | w_bus;
         5'd2:    w_alu = r_y + w_bus;
         5'd3:    w_alu = r_y - w_bus;
         5'd4:    w_alu = r_y >> w_sh;
         5'd5:    w_alu = $signed(r_y) >>> w_sh;
         5'd6:    w_alu = r_y << w_sh;
         5'd7:    w_alu = w_rot_r[31:0];
         5'd8:    w_alu = w_rot_l[63:32];
         5'd11:   w_alu = '0 - w_bus;
         5'd12:   w_alu = w_bus + 32'd1;
         5'd13:   w_alu = ~w_bus;
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      case (r_ir[20:19])
         2'b00:   w_cond = (w_bus == '0);
         2'b01:   w_cond = (w_bus != '0);
         2'b10:   w_cond = !w_bus[31] && (w_bus != '0);
         default: w_cond = w_bus[31];
      endcase
   end

   assign w_mem_rd = r_mem[r_mar[8:0]];
   assign w_unused = ^{r_mar[31:9], r_ir[31:27], w_rot_r[63:32], w_rot_l[31:0]};

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_pc  <= '0;
         r_mar <= '0;
         r_mdr <= '0;
         r_ir  <= '0;
         r_y   <= '0;
         r_z   <= '0;
         r_con <= 1'b0;
         r_out <= '0;
         for (int unsigned i = 0; i < 16; i++) r_rf[i] <= '0;
      end else begin
         if (PCin)      r_pc  <= w_bus;
         if (MARin)     r_mar <= w_bus;
         if (MDRin)     r_mdr <= Read ? w_mem_rd : w_bus;
         if (IRin)      r_ir  <= w_bus;
         if (Yin)       r_y   <= w_bus;
         if (Zin)       r_z   <= w_alu;
         if (CONin)     r_con <= w_cond;
         if (OutportIn) r_out <= w_bus;
         for (int unsigned i = 0; i < 16; i++)
            if (Rin && w_sel[i]) r_rf[i] <= w_bus;
      end
   end

   // Memory keeps its contents through reset; clr only blocks writes
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
      end else if (Write) begin
         r_mem[r_mar[8:0]] <= r_mdr;
      end
   end

   assign ConOtp     = r_con;
   assign OutportOut = r_out;

endmodule

// File: tb/tb_datapath2.sv
// Scoreboard bench for datapath2: outport observations are queued when driven
// and compared one cycle later; CON flag checked directly.
module tb_datapath2;

   logic        clk = 1'b0;
   logic        clr;
   logic        PCout, Zlowout, MDRout, MBIout, Cout, Rout, BAout;
   logic        Gra, Grb, Grc, Rin;
   logic        PCin, MARin, MDRin, IRin, Yin, Zin, CONin, OutportIn;
   logic        Read, Write;
   logic [4:0]  OpCode;
   logic [31:0] manualBusInput;
   logic        ConOtp;
   logic [31:0] OutportOut;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } sb_t;
   sb_t sb_q[$];

   int errors = 0;
   int checks = 0;

   datapath2 dut (
      .clk(clk), .clr(clr),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MBIout(MBIout), .Cout(Cout),
      .Rout(Rout), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
      .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .CONin(CONin), .OutportIn(OutportIn), .Read(Read), .Write(Write),
      .OpCode(OpCode), .manualBusInput(manualBusInput),
      .ConOtp(ConOtp), .OutportOut(OutportOut)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic idle();
      PCout = 0; Zlowout = 0; MDRout = 0; MBIout = 0; Cout = 0; Rout = 0; BAout = 0;
      Gra = 0; Grb = 0; Grc = 0; Rin = 0;
      PCin = 0; MARin = 0; MDRin = 0; IRin = 0; Yin = 0; Zin = 0; CONin = 0; OutportIn = 0;
      Read = 0; Write = 0; OpCode = '0; manualBusInput = '0;
   endtask

   task automatic drive_bus(input logic [31:0] v);
      MBIout = 1'b1;
      manualBusInput = v;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] v);
      sb_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
      OutportIn = 1'b1;
   endtask

   task automatic tick();
      logic obs;
      sb_t  e;
      obs = OutportIn;
      @(posedge clk);
      #1;
      if (obs) begin
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow got=empty exp=entry");
         end else begin
            e = sb_q.pop_front();
            check(e.tag, OutportOut, e.val);
         end
      end
      idle();
   endtask

   task automatic cond_case(input string tag, input logic [31:0] ir, input logic [31:0] r6,
                            input logic exp);
      drive_bus(ir); IRin = 1; tick();
      drive_bus(r6); Gra = 1; Rin = 1; tick();
      Gra = 1; Rout = 1; CONin = 1; tick();
      check(tag, {31'b0, ConOtp}, {31'b0, exp});
   endtask

   task automatic alu_case(input string tag, input logic [31:0] y, input logic [31:0] b,
                           input logic [4:0] op, input logic [31:0] exp);
      drive_bus(y); Yin = 1; tick();
      drive_bus(b); OpCode = op; Zin = 1; tick();
      Zlowout = 1; expect_out(tag, exp); tick();
   endtask

   initial begin
      idle();
      clr = 1'b0;
      #12;
      check("rst_con", {31'b0, ConOtp}, 32'd0);
      check("rst_out", OutportOut, 32'd0);
      @(negedge clk);
      clr = 1'b1;

      // fetch
      drive_bus(32'h0); PCin = 1; tick();
      drive_bus(32'h0); MARin = 1; tick();
      drive_bus(32'h9B000019); MDRin = 1; tick();
      Write = 1; tick();
      PCout = 1; MARin = 1; OpCode = 5'd12; Zin = 1; tick();
      Zlowout = 1; PCin = 1; tick();
      Read = 1; MDRin = 1; tick();
      MDRout = 1; IRin = 1; tick();
      PCout = 1; expect_out("fetch_pc", 32'd1); tick();
      MDRout = 1; expect_out("fetch_mdr", 32'h9B000019); tick();
      Cout = 1; expect_out("fetch_ir_c", 32'h00000019); tick();

      // branch taken
      drive_bus(32'h0); Gra = 1; Rin = 1; tick();
      Gra = 1; Rout = 1; CONin = 1; tick();
      check("br_taken_con", {31'b0, ConOtp}, 32'd1);
      PCout = 1; Yin = 1; tick();
      Cout = 1; OpCode = 5'd2; Zin = 1; tick();
      Zlowout = 1; PCin = 1; tick();
      PCout = 1; expect_out("br_pc", 32'd26); tick();

      cond_case("c00_r5",   32'h9B000019, 32'd5,        1'b0);
      cond_case("c01_r5",   32'h9B080019, 32'd5,        1'b1);
      cond_case("c01_r0",   32'h9B080019, 32'd0,        1'b0);
      cond_case("c10_r5",   32'h9B100019, 32'd5,        1'b1);
      cond_case("c10_neg",  32'h9B100019, 32'h80000000, 1'b0);
      cond_case("c10_r0",   32'h9B100019, 32'd0,        1'b0);
      cond_case("c11_neg",  32'h9B180019, 32'h80000000, 1'b1);
      cond_case("c11_r5",   32'h9B180019, 32'd5,        1'b0);

      alu_case("shra",   32'h80000000, 32'd4, 5'd5,  32'hF8000000);
      alu_case("shr",    32'h80000000, 32'd4, 5'd4,  32'h08000000);
      alu_case("rol",    32'h80000000, 32'd4, 5'd8,  32'h00000008);
      alu_case("ror",    32'h80000000, 32'd4, 5'd7,  32'h08000000);
      alu_case("shl",    32'h80000000, 32'd4, 5'd6,  32'h00000000);
      alu_case("and",    32'h80000000, 32'd4, 5'd0,  32'h00000000);
      alu_case("or",     32'h80000000, 32'd4, 5'd1,  32'h80000004);
      alu_case("add",    32'h80000000, 32'd4, 5'd2,  32'h80000004);
      alu_case("sub",    32'h80000000, 32'd4, 5'd3,  32'h7FFFFFFC);
      alu_case("neg",    32'h80000000, 32'd4, 5'd11, 32'hFFFFFFFC);
      alu_case("inc",    32'h80000000, 32'd4, 5'd12, 32'h00000005);
      alu_case("not",    32'h80000000, 32'd4, 5'd13, 32'hFFFFFFFB);
      alu_case("op9",    32'h80000000, 32'd4, 5'd9,  32'h00000000);
      alu_case("op31",   32'h80000000, 32'd4, 5'd31, 32'h00000000);
      alu_case("shra0",  32'h80000000, 32'd0, 5'd5,  32'h80000000);
      alu_case("ror0",   32'h80000000, 32'd0, 5'd7,  32'h80000000);
      alu_case("rol0",   32'h80000000, 32'd0, 5'd8,  32'h80000000);
      alu_case("sub_wr", 32'd7,        32'd9, 5'd3,  32'hFFFFFFFE);
      alu_case("inc_wr", 32'd0,  32'hFFFFFFFF, 5'd12, 32'h00000000);
      alu_case("add_wr", 32'hFFFFFFFF, 32'd1, 5'd2,  32'h00000000);
      alu_case("shl36",  32'h12345678, 32'd36, 5'd6, 32'h23456780);
      alu_case("rol8",   32'h12345678, 32'd8, 5'd8,  32'h34567812);
      alu_case("ror8",   32'h12345678, 32'd8, 5'd7,  32'h78123456);

      // bus sources and priority
      drive_bus(32'h0007FFFF); IRin = 1; tick();
      drive_bus(32'h00000055); Grb = 1; Rin = 1; tick();
      Grb = 1; BAout = 1; expect_out("baout_r0", 32'h0); tick();
      Grb = 1; Rout = 1; expect_out("rout_r0", 32'h55); tick();
      Cout = 1; expect_out("cout_sext", 32'hFFFFFFFF); tick();
      expect_out("bus_idle", 32'h0); tick();
      drive_bus(32'hA5A5A5A5); PCout = 1; Zlowout = 1; expect_out("prio_mbi", 32'hA5A5A5A5); tick();
      PCout = 1; Zlowout = 1; MDRout = 1; expect_out("prio_pc", 32'd26); tick();

      // async reset mid-cycle
      drive_bus(32'd26); PCin = 1; tick();
      drive_bus(32'h0); CONin = 1; tick();
      check("con_set", {31'b0, ConOtp}, 32'd1);
      drive_bus(32'h1234); expect_out("out_1234", 32'h1234); tick();
      #3;
      clr = 1'b0;
      #1;
      check("clr_out", OutportOut, 32'd0);
      check("clr_con", {31'b0, ConOtp}, 32'd0);
      drive_bus(32'hDEAD0000); PCin = 1; MDRin = 1; Write = 1; tick();
      @(negedge clk);
      clr = 1'b1;
      PCout = 1; expect_out("clr_pc", 32'd0); tick();
      Read = 1; MDRin = 1; tick();
      MDRout = 1; expect_out("mem0_kept", 32'h9B000019); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
